// File: rtl/operand_issue_pkg.sv
// Shared decode constants and opcode classification for the operand issue stage.
package operand_issue_pkg;

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_REGIMM   = 6'h01;
    localparam logic [5:0] OP_JAL      = 6'h03;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_SLTI     = 6'h0A;
    localparam logic [5:0] OP_SLTIU    = 6'h0B;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_XORI     = 6'h0E;
    localparam logic [5:0] OP_LUI      = 6'h0F;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_LB       = 6'h20;
    localparam logic [5:0] OP_LH       = 6'h21;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_LBU      = 6'h24;
    localparam logic [5:0] OP_LHU      = 6'h25;
    localparam logic [5:0] OP_SB       = 6'h28;
    localparam logic [5:0] OP_SH       = 6'h29;
    localparam logic [5:0] OP_SW       = 6'h2B;

    localparam logic [5:0] FN_JALR     = 6'h09;

    localparam logic [4:0] RI_BLTZAL   = 5'h10;
    localparam logic [4:0] RI_BGEZAL   = 5'h11;

    // Operand-shaping class of an opcode; immediate ALU ops split by extension kind.
    typedef enum logic [3:0] {
        CLS_OTHER,
        CLS_SPECIAL,
        CLS_SPECIAL2,
        CLS_IMM_SEXT,
        CLS_IMM_ZEXT,
        CLS_LUI,
        CLS_LOAD,
        CLS_STORE,
        CLS_REGIMM,
        CLS_JAL
    } op_class_t;

    function automatic op_class_t op_class(input logic [5:0] i_op);
        case (i_op)
            OP_SPECIAL:                          return CLS_SPECIAL;
            OP_SPECIAL2:                         return CLS_SPECIAL2;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: return CLS_IMM_SEXT;
            OP_ANDI, OP_ORI, OP_XORI:            return CLS_IMM_ZEXT;
            OP_LUI:                              return CLS_LUI;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return CLS_LOAD;
            OP_SB, OP_SH, OP_SW:                 return CLS_STORE;
            OP_REGIMM:                           return CLS_REGIMM;
            OP_JAL:                              return CLS_JAL;
            default:                             return CLS_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Prioritised forwarding mux: lowest-index matching source wins, r0 is hardwired to 0.
module operand_fwd_mux #(
    parameter int DATA_W   = 32,
    parameter int FWD_SRCS = 2
) (
    input  logic [4:0]               i_addr,
    input  logic [DATA_W-1:0]        i_rf_data,
    input  logic [FWD_SRCS-1:0]      i_fwd_valid,
    input  logic [5*FWD_SRCS-1:0]    i_fwd_addr,
    input  logic [DATA_W*FWD_SRCS-1:0] i_fwd_data,
    input  logic [FWD_SRCS-1:0]      i_fwd_pending,
    output logic [DATA_W-1:0]        o_value,
    output logic                     o_hit,
    output logic                     o_pending
);

    logic [DATA_W-1:0] w_value;
    logic              w_hit;
    logic              w_pending;

    // Scan sources youngest-first and keep only the first match.
    always_comb begin
        w_value   = i_rf_data;
        w_hit     = 1'b0;
        w_pending = 1'b0;
        if (i_addr == 5'd0) begin
            w_value = '0;
        end else begin
            for (int unsigned i = 0; i < FWD_SRCS; i++) begin
                if (!w_hit && i_fwd_valid[i] && (i_fwd_addr[i*5 +: 5] == i_addr)) begin
                    w_hit     = 1'b1;
                    w_value   = i_fwd_data[i*DATA_W +: DATA_W];
                    w_pending = i_fwd_pending[i];
                end
            end
        end
    end

    assign o_value   = w_value;
    assign o_hit     = w_hit;
    assign o_pending = w_pending;

endmodule

// File: rtl/operand_issue.sv
// Operand generation between decode and execute: forwarding, load-use stall, output register.
module operand_issue
    import operand_issue_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int FWD_SRCS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          pc,
    input  logic [5:0]                 op,
    input  logic [4:0]                 rs,
    input  logic [4:0]                 rt,
    input  logic [5:0]                 funct,
    input  logic [15:0]                imm,
    input  logic [DATA_W-1:0]          rf_data_1,
    input  logic [DATA_W-1:0]          rf_data_2,
    input  logic [FWD_SRCS-1:0]        fwd_valid,
    input  logic [5*FWD_SRCS-1:0]      fwd_addr,
    input  logic [DATA_W*FWD_SRCS-1:0] fwd_data,
    input  logic [FWD_SRCS-1:0]        fwd_pending,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          operand_1,
    output logic [DATA_W-1:0]          operand_2,
    output logic [DATA_W-1:0]          store_data,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [31:0]                stall_cycles
);

    op_class_t         w_cls;
    logic              w_use_rs, w_use_rt;
    logic [DATA_W-1:0] w_rs_val, w_rt_val;
    logic              w_rs_hit, w_rt_hit;
    logic              w_rs_pend, w_rt_pend;
    logic              w_hazard, w_accept;
    logic [ADDR_W-1:0] w_pc8;
    logic [DATA_W-1:0] w_pc8_d, w_imm_sext, w_imm_zext, w_imm_lui;
    logic [DATA_W-1:0] w_op1, w_op2, w_sd;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_op1, r_op2, r_sd;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_stall;

    operand_fwd_mux #(.DATA_W(DATA_W), .FWD_SRCS(FWD_SRCS)) u_fwd_rs (
        .i_addr(rs), .i_rf_data(rf_data_1),
        .i_fwd_valid(fwd_valid), .i_fwd_addr(fwd_addr),
        .i_fwd_data(fwd_data), .i_fwd_pending(fwd_pending),
        .o_value(w_rs_val), .o_hit(w_rs_hit), .o_pending(w_rs_pend)
    );

    operand_fwd_mux #(.DATA_W(DATA_W), .FWD_SRCS(FWD_SRCS)) u_fwd_rt (
        .i_addr(rt), .i_rf_data(rf_data_2),
        .i_fwd_valid(fwd_valid), .i_fwd_addr(fwd_addr),
        .i_fwd_data(fwd_data), .i_fwd_pending(fwd_pending),
        .o_value(w_rt_val), .o_hit(w_rt_hit), .o_pending(w_rt_pend)
    );

    // Decode source usage and the load-use hazard from the winning forward source.
    always_comb begin
        w_cls    = op_class(op);
        w_use_rs = (w_cls == CLS_SPECIAL) || (w_cls == CLS_SPECIAL2) ||
                   (w_cls == CLS_IMM_SEXT) || (w_cls == CLS_IMM_ZEXT) ||
                   (w_cls == CLS_LOAD) || (w_cls == CLS_STORE);
        w_use_rt = (w_cls == CLS_SPECIAL) || (w_cls == CLS_SPECIAL2) || (w_cls == CLS_STORE);
        w_hazard = in_valid && ((w_use_rs && w_rs_hit && w_rs_pend) ||
                                (w_use_rt && w_rt_hit && w_rt_pend));
    end

    assign in_ready = !rst && !w_hazard && (!r_out_valid || out_ready) && !flush;
    assign w_accept = in_valid && in_ready;

    // Build operand_1/operand_2/store_data for the current instruction.
    always_comb begin
        w_pc8      = pc + ADDR_W'(8);
        w_pc8_d    = DATA_W'(w_pc8);
        w_imm_sext = DATA_W'(signed'(imm));
        w_imm_zext = DATA_W'(imm);
        w_imm_lui  = DATA_W'({imm, 16'h0000});
        w_op1      = '0;
        w_op2      = '0;
        w_sd       = '0;
        case (w_cls)
            CLS_SPECIAL: begin
                w_op1 = (funct == FN_JALR) ? w_pc8_d : w_rs_val;
                w_op2 = w_rt_val;
            end
            CLS_SPECIAL2: w_op1 = w_rs_val;
            CLS_IMM_SEXT, CLS_LOAD: begin
                w_op1 = w_rs_val;
                w_op2 = w_imm_sext;
            end
            CLS_IMM_ZEXT: begin
                w_op1 = w_rs_val;
                w_op2 = w_imm_zext;
            end
            CLS_LUI: w_op2 = w_imm_lui;
            CLS_STORE: begin
                w_op1 = w_rs_val;
                w_op2 = w_imm_sext;
                w_sd  = w_rt_val;
            end
            CLS_REGIMM: w_op1 = ((rt == RI_BLTZAL) || (rt == RI_BGEZAL)) ? w_pc8_d : '0;
            CLS_JAL:    w_op1 = w_pc8_d;
            default: ;
        endcase
    end

    // Output register: flush kills, acceptance loads, consumption without refill bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_sd        <= '0;
            r_pc        <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_op1       <= w_op1;
            r_op2       <= w_op2;
            r_sd        <= w_sd;
            r_pc        <= pc;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Saturating count of cycles lost to load-use hazards (flush cycles excluded).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
        end else if (w_hazard && !flush && (r_stall != '1)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign out_valid    = r_out_valid;
    assign operand_1    = r_op1;
    assign operand_2    = r_op2;
    assign store_data   = r_sd;
    assign out_pc       = r_pc;
    assign stall_cycles = r_stall;

endmodule

// File: doc/operand_issue.md
# operand_issue

Registered, parametrised operand generation stage between decode and execute. It builds operand_1, operand_2 and the store data from the decoded instruction fields. Register operands are resolved through a prioritised forwarding network instead of raw register-file reads. Load-use hazards are detected and stall the front end, and results reach EX through a valid/ready output register with flush support.

## Interface
Parameters:
- DATA_W, 32, datapath width; immediates extend to this width
- ADDR_W, 32, PC width
- FWD_SRCS, 2, number of forwarding sources; index 0 is the youngest (EX), higher indices are older (MEM, WB, ...)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  kill the output register and any stall
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted this cycle when in_valid&&in_ready
- pc  in  ADDR_W  instruction PC
- op  in  6  opcode
- rs, rt  in  5 each  source register addresses
- funct  in  6  SPECIAL function field
- imm  in  16  immediate
- rf_data_1, rf_data_2  in  DATA_W each  register-file read of rs, rt
- fwd_valid  in  FWD_SRCS  source i writes a register
- fwd_addr  in  5*FWD_SRCS  destination register of source i
- fwd_data  in  DATA_W*FWD_SRCS  result of source i
- fwd_pending  in  FWD_SRCS  source i result not yet available (load in flight)
- out_valid  out  1  registered operands valid
- out_ready  in  1  EX accepts this cycle
- operand_1, operand_2, store_data  out  DATA_W each  registered operands
- out_pc  out  ADDR_W  registered PC
- stall_cycles  out  32  count of cycles lost to load-use hazards

## Operation
- Resolved value of rs (rt is resolved the same way) is the lowest-index i with fwd_valid[i] && fwd_addr[i]==rs && rs!=0, giving fwd_data[i]. With no match the value is rf_data_1. Register 0 always resolves to 0.
- A register is used when it is a source for the current op. rs is used by SPECIAL, SPECIAL2, the immediate ALU ops, loads and stores. rt is used by SPECIAL, SPECIAL2 and stores.
- Hazard condition: in_valid, a used register resolves to source i, and fwd_pending[i] is set. Only the winning, lowest-index match counts.
- operand_1:
  - SPECIAL: pc+8 when funct==JALR, otherwise resolved rs.
  - Immediate ALU ops, loads, stores and SPECIAL2: resolved rs.
  - REGIMM: pc+8 when rt is BLTZAL or BGEZAL, otherwise 0.
  - JAL: pc+8.
  - Any other opcode: 0.
- operand_2:
  - LUI: {imm,16'b0} zero-extended to DATA_W.
  - ADDI, ADDIU, SLTI, SLTIU, loads and stores: sign-extended imm.
  - SPECIAL: resolved rt.
  - ANDI, ORI, XORI: zero-extended imm.
  - Any other opcode: 0.
- store_data: resolved rt for SB, SH and SW; 0 for everything else.
- pc+8 wraps modulo 2^ADDR_W and is then zero-extended or truncated to DATA_W.
- in_ready = !hazard && (!out_valid || out_ready) && !flush.
- Output register:
  - On acceptance, the register loads operands and pc and out_valid becomes 1.
  - If there is no acceptance and out_ready is high, out_valid becomes 0 (bubble).
  - Otherwise the register holds.
- stall_cycles increments by 1 in each cycle where hazard && !flush. It saturates at 2^32-1.

## Timing
- Reset values: out_valid=0, operand_1=operand_2=store_data=0, out_pc=0, stall_cycles=0. in_ready is 0 while rst is high.
- Latency is 1 cycle: an instruction accepted at edge N is visible on the outputs after edge N and remains there until out_ready is sampled high.
- Handshake: the outputs are stable while out_valid && !out_ready. Flush is the only exception.
- Flush has priority over everything except rst. The next edge forces out_valid=0 and no instruction is accepted in the flush cycle. stall_cycles does not count flush cycles.
- A hazard clears in the same cycle fwd_pending drops. in_ready then rises combinationally and the accepted operands carry the now-ready fwd_data.
- Asserting rst mid-stall or mid-handshake returns every output to its reset value at the next edge. stall_cycles is cleared as well.

## Structure
- The opcode, funct and REGIMM constants come from the shared include headers (opcode, funct, regimm, bus). No new constants are defined locally.
- One sub-module, operand_fwd_mux, parametrised by DATA_W and FWD_SRCS. It takes an address, the register-file value and the forwarding vectors. It produces the resolved value, a hit flag and a pending flag, and is instantiated once for rs and once for rt.

## Test plan
- ORI, rs=3, rf_data_1=0x12340000, imm=0x00FF, no forwarding -> one cycle later operand_1=0x12340000, operand_2=0x000000FF, out_valid=1.
- ADDI, rs=5, fwd0 and fwd1 both target r5 with 0xAAAA and 0xBBBB -> operand_1=0xAAAA; with rs=0 and fwd0 targeting r0 -> operand_1=0.
- SW, rt=7, fwd1 targets r7 with pending=1 for 3 cycles, then 0x55 -> in_ready low for 3 cycles, stall_cycles=3, then store_data=0x55 and operand_2=sign-extended imm 0xFFFC -> 0xFFFFFFFC.
- JAL at pc=0xFFFFFFFC -> operand_1=0x00000004; REGIMM BGEZAL at pc=0x100 -> operand_1=0x108; REGIMM BLTZ -> operand_1=0.
- out_ready held low for 4 cycles with a valid LUI imm=0x8000 -> operand_2 stays 0x80000000 and in_ready stays 0; flush in cycle 2 -> out_valid=0 next edge.
- rst asserted during a hazard stall with stall_cycles=2 -> all outputs 0 next edge; stall_cycles=0.
